// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and
// the default frame start marker.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus the byte-write port into the
// instruction memory. The loader sits on the slave side; the byte source
// and memory model sit on the master side.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC, LEN (16-bit little endian), payload, CSUM frames
// from a byte stream, writes the payload into instruction memory from
// address 0 and releases the CPU reset only once the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         MEM_NBYTE = 4096,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus,
  input  logic          reload,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          error
);

  // Lengths above this are rejected; LEN == MEM_NBYTE itself is legal.
  localparam logic [16:0] MAX_LEN = 17'(MEM_NBYTE);

  state_t      state;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  csum;
  logic        we_q;
  logic [31:0] addr_q;
  logic [7:0]  wdata_q;

  logic        accept;
  logic [15:0] len_full;
  logic        too_long;
  logic        last_byte;

  // Flow control and status are pure decodes of the registered state.
  always_comb begin
    bus.rx_ready = (state != DONE) && (state != ERR);
    busy         = (state == LEN_LO) || (state == LEN_HI) ||
                   (state == DATA)   || (state == CSUM);
    done         = (state == DONE);
    error        = (state == ERR);
  end

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign len_full  = {bus.rx_data, len[7:0]};
  assign too_long  = {1'b0, len_full} > MAX_LEN;
  // idx stops at LEN-1, so it can never run past the memory.
  assign last_byte = (idx == len - 16'd1);

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // Frame FSM with byte counter, running checksum and registered write port.
  // Reset wins over a byte accepted on the same edge, so no write escapes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      idx       <= '0;
      csum      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_n <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && bus.rx_data == SYNC_BYTE) begin
            state <= LEN_LO;
            idx   <= '0;
            csum  <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.rx_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= bus.rx_data;
            if (too_long)               state <= ERR;
            else if (len_full == 16'd0) state <= CSUM;
            else                        state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            we_q    <= 1'b1;
            addr_q  <= {16'd0, idx};
            wdata_q <= bus.rx_data;
            csum    <= csum + bus.rx_data;
            if (last_byte) state <= CSUM;
            else           idx   <= idx + 16'd1;
          end
        end
        CSUM: begin
          if (accept) begin
            if (bus.rx_data == csum) begin
              state     <= DONE;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= ERR;
            end
          end
        end
        DONE: begin
          if (reload) begin
            state     <= IDLE;
            cpu_rst_n <= 1'b0;
          end
        end
        ERR: begin
          if (reload) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a frame-level reference model
// predicts the memory writes and final outcome of every frame sent.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int         MEM_NBYTE = 4096;
  localparam logic [7:0] SYNC      = 8'hA5;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reload = 1'b0;
  logic cpu_rst_n, busy, done, error;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  imem_loader_if bus();

  imem_loader #(.MEM_NBYTE(MEM_NBYTE), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .reload(reload),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: skip to the first SYNC, read LEN, queue one write per
  // payload byte and judge the checksum. 1 = done, 2 = error, 0 = cut short.
  function automatic int model(input bq_t f);
    int i = 0;
    int len;
    int sum = 0;
    while (i < f.size() && f[i] != SYNC) i++;
    i++;
    if (i + 1 >= f.size()) return 0;
    len = int'(f[i]) + 256 * int'(f[i+1]);
    i += 2;
    if (len > MEM_NBYTE) return 2;
    for (int k = 0; k < len && i + k < f.size(); k++) begin
      exp_q.push_back({32'(k), f[i+k]});
      sum += int'(f[i+k]);
    end
    if (i + len >= f.size()) return 0;
    return (int'(f[i+len]) == sum % 256) ? 1 : 2;
  endfunction

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", {24'd0, bus.mem_wdata}, {24'd0, e.data});
      end
    end
  end

  // Drive one byte and hold it until accepted; called #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps)
      while ($urandom_range(0, 2) == 0) begin
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL rx_ready_timeout: byte %0h never accepted", b);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  // Send a whole frame, optionally stalling before byte stall_at (with a
  // stray reload pulse that must be ignored), then check the outcome.
  task automatic run_frame(input string name, input bq_t f, input bit gaps, input int stall_at);
    int res;
    res = model(f);
    for (int i = 0; i < f.size(); i++) begin
      if (i == stall_at) begin
        repeat (20) begin
          @(posedge clk); #1;
        end
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        chk({name, "_stall_busy"}, {31'd0, busy}, 32'd1);
      end
      if (i == f.size() - 1) chk({name, "_cpu_rst_pre"}, {31'd0, cpu_rst_n}, 32'd0);
      send_byte(f[i], gaps);
    end
    chk({name, "_done"},      {31'd0, done},        {31'd0, res == 1});
    chk({name, "_error"},     {31'd0, error},       {31'd0, res == 2});
    chk({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n},   {31'd0, res == 1});
    chk({name, "_rx_ready"},  {31'd0, bus.rx_ready}, 32'd0);
    chk({name, "_busy"},      {31'd0, busy},        32'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    chk("reload_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    chk("reload_cpu_rst",  {31'd0, cpu_rst_n},    32'd0);
    chk("reload_status",   {30'd0, done, error},  32'd0);
  endtask

  initial begin
    bq_t f;
    int  len, g, sum;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset values.
    @(posedge clk); #1;
    chk("rst_mem_we",    {31'd0, bus.mem_we},   32'd0);
    chk("rst_mem_addr",  bus.mem_addr,          32'd0);
    chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    chk("rst_status",    {28'd0, cpu_rst_n, done, error, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

    // Directed frames.
    f = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_frame("fr_basic", f, 1'b1, 5);
    do_reload();

    f = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h04};
    run_frame("fr_badsum", f, 1'b0, -1);
    do_reload();

    f = '{8'hA5, 8'h01, 8'h10};
    run_frame("fr_toolong", f, 1'b0, -1);
    do_reload();

    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("fr_zero_ok", f, 1'b0, -1);
    do_reload();
    f = '{8'hA5, 8'h00, 8'h00, 8'h01};
    run_frame("fr_zero_bad", f, 1'b0, -1);
    do_reload();

    f = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
    f = '{8'hA5, 8'h03, 8'h00, 8'hA5, 8'hA5, 8'h01, 8'h4B};
    run_frame("fr_sync_in_data", f, 1'b1, -1);
    do_reload();

    // Full-size image: last write lands at MEM_NBYTE-1.
    f = '{8'hA5, 8'h00, 8'h10};
    sum = 0;
    for (int k = 0; k < MEM_NBYTE; k++) begin
      f.push_back(8'($urandom));
      sum += int'(f[f.size()-1]);
    end
    f.push_back(8'(sum));
    run_frame("fr_full", f, 1'b0, -1);
    do_reload();

    // Random frames: garbage prefix, random lengths, some corrupted sums.
    for (int n = 0; n < 20; n++) begin
      f = {};
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) f.push_back(8'($urandom_range(0, 8'hA4)));
      f.push_back(SYNC);
      len = $urandom_range(0, 20);
      f.push_back(8'(len));
      f.push_back(8'h00);
      sum = 0;
      for (int k = 0; k < len; k++) begin
        f.push_back(8'($urandom));
        sum += int'(f[f.size()-1]);
      end
      if ($urandom_range(0, 2) == 0) sum += $urandom_range(1, 255);
      f.push_back(8'(sum));
      run_frame("fr_rand", f, 1'b1,
                ($urandom_range(0, 1) == 1) ? g + 1 + $urandom_range(0, len + 2) : -1);
      do_reload();
    end

    // Reset after payload byte 8 of a 16-byte frame, with byte 9 offered on
    // the reset edge: only the first eight writes may appear.
    f = '{8'hA5, 8'h10, 8'h00};
    for (int k = 0; k < 8; k++) f.push_back(8'($urandom));
    void'(model(f));
    foreach (f[i]) send_byte(f[i], 1'b1);
    rst_n        = 1'b0;
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    chk("midrst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("midrst_status", {28'd0, cpu_rst_n, done, error, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("midrst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    chk("midrst_drain",    32'(exp_q.size()),     32'd0);

    // Loader still works after the aborted frame.
    f = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30};
    run_frame("fr_after_rst", f, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_NBYTE, default 4096, is the instruction memory size in bytes and the maximum payload length.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, is the frame start marker.
REQ-003 clk  input  1  single clock; all logic rising-edge triggered.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 rx_data  input  8  incoming byte stream, for example from a UART receiver.
REQ-006 rx_valid  input  1  rx_data holds a byte.
REQ-007 rx_ready  output  1  loader accepts the byte; transfer occurs when rx_valid && rx_ready at a clock edge.
REQ-008 reload  input  1  single-cycle request to re-arm from DONE or ERR.
REQ-009 mem_we  output  1  byte write strobe to the instruction memory write port.
REQ-010 mem_addr  output  32  byte address of the write.
REQ-011 mem_wdata  output  8  write byte.
REQ-012 cpu_rst_n  output  1  CPU core reset, held low while no valid image is loaded.
REQ-013 busy  output  1  frame in progress (states LEN_LO through CSUM).
REQ-014 done  output  1  image loaded and checksum verified.
REQ-015 error  output  1  frame rejected.

Function
REQ-016 Frame format: SYNC_BYTE, LEN[7:0], LEN[15:8], LEN payload bytes, CSUM.
- CSUM equals the 8-bit modulo-256 sum of the payload bytes.
REQ-017 FSM states and transitions:
- IDLE: a byte equal to SYNC_BYTE goes to LEN_LO; any other byte is consumed and discarded, remaining in IDLE.
- LEN_LO goes to LEN_HI.
- LEN_HI: LEN > MEM_NBYTE goes to ERR; LEN == 0 goes to CSUM; otherwise goes to DATA.
- DATA goes to CSUM when the LENth byte is accepted.
- CSUM: a match goes to DONE; a mismatch goes to ERR.
- DONE and ERR go to IDLE when reload is high; otherwise they hold.
REQ-018 rx_ready shall be 1 in IDLE, LEN_LO, LEN_HI, DATA and CSUM, and 0 in DONE and ERR; it is a combinational function of state only.
REQ-019 The loader shall advance state only on an accepted byte (or on reload); rx_valid low stalls the FSM indefinitely with no timeout.
REQ-020 Each payload byte accepted at edge N shall produce mem_we = 1, mem_wdata = byte and mem_addr = byte index (0, 1, 2, ...) as registered outputs during cycle N+1.
- mem_we is a one-cycle pulse per byte; back-to-back bytes give back-to-back pulses.
REQ-021 The byte index counter is 16 bits, is cleared on entry to LEN_LO, and never exceeds LEN-1 because of REQ-017.
- mem_addr is the counter zero-extended to 32 bits; no wrap-around is possible.
REQ-022 The running checksum is an 8-bit register, cleared on entry to LEN_LO, with each payload byte added modulo 256.
REQ-023 cpu_rst_n is registered and is 1 exactly while the state is DONE: it rises on the edge entering DONE and falls on the edge leaving DONE.
REQ-024 done = (state == DONE); error = (state == ERR); both are glitch-free decodes of the registered state.
REQ-025 reload is ignored in every state other than DONE and ERR.
REQ-026 A SYNC_BYTE value arriving inside LEN or payload fields shall be treated as data; no resynchronisation occurs mid-frame.
REQ-027 LEN == MEM_NBYTE is legal; the last write address is MEM_NBYTE-1.

Reset
REQ-028 With rst_n low at a clock edge, the block shall enter IDLE with the following values:
- byte index counter = 0, checksum = 0
- mem_we = 0, mem_addr = 0, mem_wdata = 0
- cpu_rst_n = 0, done = 0, error = 0, busy = 0
REQ-029 Reset mid-frame shall abort the frame.
- No further mem_we pulse is issued, including one pending from a byte accepted at the reset edge.
- Memory already written is left unchanged.
REQ-030 rx_ready shall be 1 in the first cycle after reset deasserts.

Structure
REQ-031 Package imem_loader_pkg holds the state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR) and the SYNC_BYTE default.
REQ-032 The block has no sub-module; FSM, counter and checksum are implemented inline.
- The write port connects to a byte-write port added to the instruction memory.

Verification
REQ-033 Frame A5 04 00 13 00 00 00 13 -> writes to addr 0..3 of 13, 00, 00, 00; done = 1; cpu_rst_n rises on the edge accepting CSUM.
REQ-034 Garbage 00 FF then A5 02 00 01 02 04 -> two garbage bytes discarded; CSUM mismatch (expected 03); error = 1; cpu_rst_n stays 0; rx_ready = 0; then reload pulse -> IDLE, rx_ready = 1.
REQ-035 A5 01 10 (LEN = 4097 with MEM_NBYTE = 4096) -> ERR after LEN_HI; no mem_we issued.
REQ-036 A5 00 00 00 -> zero-length frame goes to DONE with no writes.
- Then A5 00 00 01 after reload -> ERR.
REQ-037 rx_valid toggling randomly during a 16-byte payload -> exactly 16 mem_we pulses with addresses 0..15 in order.
- Assert rst_n low after byte 8 is accepted -> no further pulses, IDLE, cpu_rst_n = 0.
